// File: rtl/m_mul_sequencer.sv
// Multi-cycle shift-add multiplier sequencer for the EX stage; stalls the pipeline while a mul runs.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module m_mul_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       alucontrol,
   input  logic             ex_valid,
   input  logic             ex_hold,
   input  logic             flush,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             stall,
   output logic             mul_valid,
   output logic [WIDTH-1:0] mul_result
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [2:0]    ALU_MUL  = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [WIDTH-1:0] acc_r;
   logic [CW-1:0]    cnt_r;

   logic             start_s;
   logic             last_s;
   logic [WIDTH-1:0] acc_next_s;
   logic [WIDTH-1:0] mplier_next_s;

   // Start decode, one shift-add step, termination test and the pipeline stall
   always_comb begin
      start_s       = (state_r == IDLE) && ex_valid && (alucontrol == ALU_MUL) && !flush;
      mplier_next_s = mplier_r >> 1'b1;
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
`ifdef MUL_EARLY_TERM_EN
      last_s = (cnt_r == LAST_CNT) || (mplier_next_s == {WIDTH{1'b0}});
`else
      last_s = (cnt_r == LAST_CNT);
`endif
      // A flush releases the pipeline in the same cycle it is seen
      stall = start_s || ((state_r == BUSY) && !flush);
   end

   // Sequencer state, operand/accumulator datapath and registered result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         mcand_r    <= {WIDTH{1'b0}};
         mplier_r   <= {WIDTH{1'b0}};
         acc_r      <= {WIDTH{1'b0}};
         cnt_r      <= {CW{1'b0}};
         mul_valid  <= 1'b0;
         mul_result <= {WIDTH{1'b0}};
      end else if (flush) begin
         state_r   <= IDLE;
         mul_valid <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  mcand_r  <= srca;
                  mplier_r <= srcb;
                  acc_r    <= {WIDTH{1'b0}};
                  cnt_r    <= {CW{1'b0}};
                  state_r  <= BUSY;
               end
            end
            BUSY: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << 1'b1;
               mplier_r <= mplier_next_s;
               cnt_r    <= cnt_r + 1'b1;
               if (last_s) begin
                  state_r    <= DONE;
                  mul_valid  <= 1'b1;
                  mul_result <= acc_next_s;
               end
            end
            DONE: begin
               // Stay put while downstream holds; never restart from here
               if (!ex_hold) begin
                  state_r   <= IDLE;
                  mul_valid <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               mul_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m_mul_sequencer.sv
// Scoreboard bench for m_mul_sequencer (WIDTH=32); latency expectations follow MUL_EARLY_TERM_EN.
module tb_m_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  alucontrol;
   logic        ex_valid;
   logic        ex_hold;
   logic        flush;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        stall;
   logic        mul_valid;
   logic [31:0] mul_result;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_result;

   m_mul_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .alucontrol(alucontrol), .ex_valid(ex_valid),
      .ex_hold(ex_hold), .flush(flush), .srca(srca), .srcb(srcb),
      .stall(stall), .mul_valid(mul_valid), .mul_result(mul_result)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic int busy_cycles(input logic [31:0] b);
      int n;
`ifdef MUL_EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) n = i + 1;
      end
`else
      n = 32;
`endif
      return n;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Full multiply: start, count stall cycles, hold in DONE for 'hold' extra cycles, return to IDLE
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int hold);
      int          stall_cnt = 0;
      int          valid_cnt = 0;
      int          cyc = 0;
      logic [31:0] exp_prod;
      sb_q.push_back(a * b);
      ex_valid   = 1'b1;
      alucontrol = 3'b011;
      srca       = a;
      srcb       = b;
      ex_hold    = (hold > 0);
      while (valid_cnt <= hold && cyc < 200) begin
         @(negedge clk);
         if (mul_valid) begin
            valid_cnt++;
            if (valid_cnt == 1) begin
               exp_prod    = sb_q.pop_front();
               last_result = exp_prod;
               check_val("result", mul_result, exp_prod);
            end else begin
               check_val("hold_result", mul_result, last_result);
            end
            check_val("done_stall", {31'd0, stall}, 32'd0);
         end else if (stall) begin
            stall_cnt++;
         end
         next_cycle();
         cyc++;
         if (valid_cnt >= hold) ex_hold = 1'b0;
      end
      ex_valid   = 1'b0;
      alucontrol = 3'b000;
      check_val("valid_cycles", 32'(valid_cnt), 32'(hold + 1));
      check_val("stall_cycles", 32'(stall_cnt), 32'(busy_cycles(b) + 1));
      @(negedge clk);
      check_val("idle_valid", {31'd0, mul_valid}, 32'd0);
      check_val("idle_stall", {31'd0, stall}, 32'd0);
      check_val("idle_result_kept", mul_result, last_result);
      next_cycle();
   endtask

   initial begin
      int vcnt;
      reset = 1'b1; alucontrol = 3'b000; ex_valid = 1'b0; ex_hold = 1'b0;
      flush = 1'b0; srca = 32'd0; srcb = 32'd0; last_result = 32'd0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_stall", {31'd0, stall}, 32'd0);
      check_val("rst_valid", {31'd0, mul_valid}, 32'd0);
      check_val("rst_result", mul_result, 32'd0);
      next_cycle();

      run_mul(32'd7, 32'd6, 0);
      run_mul(32'hFFFFFFFF, 32'd3, 0);
      run_mul(32'h00010000, 32'h00010000, 0);
      run_mul(32'd7, 32'd6, 4);
      run_mul(32'd123456789, 32'd1, 0);
      run_mul(32'hDEADBEEF, 32'd0, 0);
      run_mul($urandom, $urandom, 0);
      run_mul(32'h0000BEEF, 32'h00000005, 2);

      // Flush at BUSY cycle 10
      ex_valid = 1'b1; alucontrol = 3'b011; srca = 32'd11; srcb = 32'h80000001;
      for (int i = 0; i < 10; i++) next_cycle();
      flush = 1'b1;
      @(negedge clk);
      check_val("flush_busy_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      flush = 1'b0; ex_valid = 1'b0; alucontrol = 3'b000;
      @(negedge clk);
      check_val("flush_idle_stall", {31'd0, stall}, 32'd0);
      check_val("flush_result_kept", mul_result, last_result);
      vcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mul_valid) vcnt++;
      end
      check_val("flush_no_valid", 32'(vcnt), 32'd0);
      next_cycle();

      // Flush in the start cycle suppresses the start
      ex_valid = 1'b1; alucontrol = 3'b011; srca = 32'd3; srcb = 32'h80000003; flush = 1'b1;
      @(negedge clk);
      check_val("flush_start_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      flush = 1'b0; ex_valid = 1'b0; alucontrol = 3'b000;
      @(negedge clk);
      check_val("flush_start_nostart", {31'd0, stall}, 32'd0);
      check_val("flush_start_valid", {31'd0, mul_valid}, 32'd0);
      next_cycle();

      // Reset at BUSY cycle 5
      ex_valid = 1'b1; alucontrol = 3'b011; srca = 32'd9; srcb = 32'h80000005;
      for (int i = 0; i < 5; i++) next_cycle();
      @(negedge clk);
      check_val("pre_rst_stall", {31'd0, stall}, 32'd1);
      next_cycle();
      reset = 1'b1; ex_valid = 1'b0; alucontrol = 3'b000;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check_val("midrst_stall", {31'd0, stall}, 32'd0);
      check_val("midrst_valid", {31'd0, mul_valid}, 32'd0);
      check_val("midrst_result", mul_result, 32'd0);
      last_result = 32'd0;
      next_cycle();

      run_mul(32'hFFFFFFFE, 32'hFFFFFFFF, 0);
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
